// File: rtl/argmax_row_engine_pkg.sv
// argmax_pkg: shared FSM state encoding and width helper for the argmax row engine
package argmax_pkg;

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/argmax_row_engine_if.sv
// argmax_row_engine_if: request/valid row read port toward the combination result memory
interface argmax_row_engine_if #(
    parameter int NUM_COLS   = 3,
    parameter int DATA_WIDTH = 16,
    parameter int ROW_W      = 3
);
    logic                  rd_en;
    logic [ROW_W-1:0]      rd_addr;
    logic                  rd_valid;
    logic [DATA_WIDTH-1:0] rd_data [0:NUM_COLS-1];

    modport master (output rd_en, rd_addr, input rd_valid, rd_data);
    modport slave  (input rd_en, rd_addr, output rd_valid, rd_data);
endinterface

// File: rtl/argmax_row_engine_cmp_tree.sv
// argmax_cmp_tree: combinational binary reduction tree returning {idx,val} of the row maximum
module argmax_cmp_tree
    import argmax_pkg::*;
#(
    parameter int NUM_COLS   = 3,
    parameter int DATA_WIDTH = 16,
    parameter int SIGNED     = 0,
    parameter int IDX_W      = clog2_min1(NUM_COLS)
) (
    input  logic [DATA_WIDTH-1:0] data [0:NUM_COLS-1],
    output logic [IDX_W-1:0]      idx,
    output logic [DATA_WIDTH-1:0] val
);
    localparam int P = 1 << clog2_min1(NUM_COLS);

    // Heap layout: node n combines 2n (lower columns) and 2n+1; padding leaves are invalid
    logic [DATA_WIDTH-1:0] v  [1:2*P-1];
    logic [IDX_W-1:0]      ix [1:2*P-1];
    logic                  ok [1:2*P-1];

    function automatic logic gt(input logic [DATA_WIDTH-1:0] a, input logic [DATA_WIDTH-1:0] b);
        return (SIGNED != 0) ? ($signed(a) > $signed(b)) : (a > b);
    endfunction

    always_comb begin
        for (int i = 1; i < 2 * P; i++) begin
            v[i]  = '0;
            ix[i] = '0;
            ok[i] = 1'b0;
        end
        for (int i = 0; i < NUM_COLS; i++) begin
            v[P+i]  = data[i];
            ix[P+i] = IDX_W'(i);
            ok[P+i] = 1'b1;
        end
        // Right child wins only when strictly greater, so ties keep the lower index
        for (int n = P - 1; n >= 1; n--) begin
            v[n]  = (ok[2*n+1] && (!ok[2*n] || gt(v[2*n+1], v[2*n]))) ? v[2*n+1]  : v[2*n];
            ix[n] = (ok[2*n+1] && (!ok[2*n] || gt(v[2*n+1], v[2*n]))) ? ix[2*n+1] : ix[2*n];
            ok[n] = ok[2*n] || ok[2*n+1];
        end
    end

    assign idx = ix[1];
    assign val = v[1];

endmodule

// File: rtl/argmax_row_engine.sv
// argmax_row_engine: scans result memory row by row, storing argmax index and max value per row
module argmax_row_engine
    import argmax_pkg::*;
#(
    parameter int NUM_ROWS   = 6,
    parameter int NUM_COLS   = 3,
    parameter int DATA_WIDTH = 16,
    parameter int SIGNED     = 0,
    parameter int IDX_W      = clog2_min1(NUM_COLS),
    parameter int ROW_W      = clog2_min1(NUM_ROWS)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    argmax_row_engine_if.master   rd,
    output logic                  busy,
    output logic                  done,
    output logic [IDX_W-1:0]      max_idx [0:NUM_ROWS-1],
    output logic [DATA_WIDTH-1:0] max_val [0:NUM_ROWS-1]
);
    state_t                state, state_n;
    logic [ROW_W-1:0]      row;
    logic                  start_q;
    logic                  launch;
    logic                  last;
    logic [IDX_W-1:0]      c_idx;
    logic [DATA_WIDTH-1:0] c_val;

    argmax_cmp_tree #(
        .NUM_COLS  (NUM_COLS),
        .DATA_WIDTH(DATA_WIDTH),
        .SIGNED    (SIGNED),
        .IDX_W     (IDX_W)
    ) u_tree (
        .data(rd.rd_data),
        .idx (c_idx),
        .val (c_val)
    );

    assign launch     = start & ~start_q;
    assign last       = row == ROW_W'(NUM_ROWS - 1);
    assign rd.rd_en   = state == REQ;
    assign rd.rd_addr = row;
    assign busy       = state == REQ || state == WAIT;
    assign done       = state == DONE;

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE, DONE: state_n = launch ? REQ : state;
            REQ:        state_n = WAIT;
            WAIT:       state_n = rd.rd_valid ? (last ? DONE : REQ) : WAIT;
            default:    state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state   <= IDLE;
            row     <= '0;
            start_q <= 1'b0;
            for (int r = 0; r < NUM_ROWS; r++) begin
                max_idx[r] <= '0;
                max_val[r] <= '0;
            end
        end else begin
            state   <= state_n;
            start_q <= start;
            if ((state == IDLE || state == DONE) && launch)
                row <= '0;
            else if (state == WAIT && rd.rd_valid) begin
                max_idx[row] <= c_idx;
                max_val[row] <= c_val;
                row          <= last ? row : row + ROW_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_argmax_row_engine.sv
// tb_argmax_row_engine: directed scans against a latency-configurable memory model with a result scoreboard
module tb_argmax_row_engine;

    typedef struct {
        int          row;
        logic [1:0]  idx;
        logic [15:0] val;
    } exp_t;

    logic clk = 1'b0;
    logic reset, start, s_start, o_start;
    logic busy, done, s_busy, s_done, o_busy, o_done;
    logic [1:0]  max_idx [0:5];
    logic [15:0] max_val [0:5];
    logic [1:0]  s_idx [0:0];
    logic [15:0] s_val [0:0];
    logic [0:0]  o_idx [0:0];
    logic [15:0] o_val [0:0];

    int tests = 0;
    int fails = 0;

    logic [15:0] mem [0:5][0:2];
    exp_t q[$];
    int   lat, cnt, addr, req_cnt, spur_req, spur_ack;
    bit   rnd, ignore_resp, pend;
    logic busy1, done1;
    logic [15:0] v5;

    argmax_row_engine_if #(.NUM_COLS(3), .DATA_WIDTH(16), .ROW_W(3)) m ();
    argmax_row_engine_if #(.NUM_COLS(3), .DATA_WIDTH(16), .ROW_W(1)) s ();
    argmax_row_engine_if #(.NUM_COLS(1), .DATA_WIDTH(16), .ROW_W(1)) o ();

    argmax_row_engine #(.NUM_ROWS(6), .NUM_COLS(3), .DATA_WIDTH(16), .SIGNED(0)) u_dut (
        .clk(clk), .reset(reset), .start(start), .rd(m.master),
        .busy(busy), .done(done), .max_idx(max_idx), .max_val(max_val)
    );

    argmax_row_engine #(.NUM_ROWS(1), .NUM_COLS(3), .DATA_WIDTH(16), .SIGNED(1)) u_sgn (
        .clk(clk), .reset(reset), .start(s_start), .rd(s.master),
        .busy(s_busy), .done(s_done), .max_idx(s_idx), .max_val(s_val)
    );

    argmax_row_engine #(.NUM_ROWS(1), .NUM_COLS(1), .DATA_WIDTH(16), .SIGNED(0)) u_one (
        .clk(clk), .reset(reset), .start(o_start), .rd(o.master),
        .busy(o_busy), .done(o_done), .max_idx(o_idx), .max_val(o_val)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Linear unsigned scan, strict '>' keeps the first maximum
    function automatic exp_t ref_row(input int a);
        exp_t e;
        e.row = a;
        e.idx = 2'd0;
        e.val = mem[a][0];
        for (int c = 1; c < 3; c++)
            if (mem[a][c] > e.val) begin
                e.idx = c[1:0];
                e.val = mem[a][c];
            end
        return e;
    endfunction

    task automatic chk_zero(input string tag);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_rd_en"}, 32'(m.rd_en), 32'd0);
        for (int r = 0; r < 6; r++) begin
            chk({tag, "_idx"}, 32'(max_idx[r]), 32'd0);
            chk({tag, "_val"}, 32'(max_val[r]), 32'd0);
        end
    endtask

    task automatic scan(output int n);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        busy1 = busy;
        done1 = done;
        v5    = max_val[5];
        n = 0;
        while (!done && n < 1000) begin
            @(posedge clk);
            #1;
            n++;
        end
        @(negedge clk);
        start = 1'b0;
    endtask

    // Memory model and scoreboard: answers each request after the chosen latency
    initial begin
        exp_t e;
        m.rd_valid = 1'b0;
        for (int c = 0; c < 3; c++) m.rd_data[c] = '0;
        forever begin
            @(posedge clk);
            #1;
            if (pend) begin
                pend = 1'b0;
                e = q.pop_front();
                chk("row_idx", 32'(max_idx[e.row]), 32'(e.idx));
                chk("row_val", 32'(max_val[e.row]), 32'(e.val));
            end
            m.rd_valid = 1'b0;
            if (spur_req != spur_ack) begin
                spur_ack   = spur_req;
                m.rd_valid = 1'b1;
                m.rd_data  = '{16'h1234, 16'hBEEF, 16'h7777};
            end
            if (cnt > 0) begin
                cnt--;
                if (cnt == 0 && addr < 6) begin
                    m.rd_valid = 1'b1;
                    for (int c = 0; c < 3; c++) m.rd_data[c] = mem[addr][c];
                    if (!ignore_resp) begin
                        q.push_back(ref_row(addr));
                        pend = 1'b1;
                    end
                end
            end
            if (m.rd_en) begin
                chk("no_overlap", 32'(cnt), 32'd0);
                req_cnt++;
                cnt  = rnd ? int'($urandom_range(7, 1)) : lat;
                addr = int'(m.rd_addr);
            end
        end
    end

    initial begin
        int n, k, r0;
        int e_idx[6] = '{1, 0, 0, 2, 0, 1};
        int e_val[6] = '{9, 7, 0, 3, 65535, 8};
        reset = 1'b0; start = 1'b0; s_start = 1'b0; o_start = 1'b0;
        lat = 1; rnd = 1'b0; ignore_resp = 1'b0; pend = 1'b0;
        cnt = 0; addr = 0; req_cnt = 0; spur_req = 0; spur_ack = 0;
        s.rd_valid = 1'b0; o.rd_valid = 1'b0; o.rd_data[0] = '0;
        for (int c = 0; c < 3; c++) s.rd_data[c] = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_zero("reset");
        reset = 1'b1;

        mem = '{'{16'd5, 16'd9, 16'd2}, '{16'd7, 16'd7, 16'd1}, '{16'd0, 16'd0, 16'd0},
                '{16'd1, 16'd2, 16'd3}, '{16'd65535, 16'd0, 16'd1}, '{16'd4, 16'd8, 16'd8}};
        scan(n);
        chk("l1_launch_busy", 32'(busy1), 32'd1);
        chk("l1_cycles", 32'(n), 32'd12);
        chk("l1_done", 32'(done), 32'd1);
        for (int r = 0; r < 6; r++) begin
            chk("l1_idx", 32'(max_idx[r]), 32'(e_idx[r]));
            chk("l1_val", 32'(max_val[r]), 32'(e_val[r]));
        end

        // Stray rd_valid while DONE must not touch results
        r0 = req_cnt;
        spur_req++;
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("spur_done", 32'(done), 32'd1);
        chk("spur_busy", 32'(busy), 32'd0);
        chk("spur_reqs", 32'(req_cnt - r0), 32'd0);
        for (int r = 0; r < 6; r++) begin
            chk("spur_idx", 32'(max_idx[r]), 32'(e_idx[r]));
            chk("spur_val", 32'(max_val[r]), 32'(e_val[r]));
        end

        // Rescan from DONE with random latency and fresh data
        rnd = 1'b1;
        mem[0] = '{16'hFFFF, 16'h0001, 16'h8000};
        mem[2] = '{16'h00A5, 16'h00A5, 16'h00A5};
        for (int r = 1; r < 6; r++)
            if (r != 2) for (int c = 0; c < 3; c++) mem[r][c] = 16'($urandom);
        scan(n);
        chk("re_launch_busy", 32'(busy1), 32'd1);
        chk("re_launch_done", 32'(done1), 32'd0);
        chk("re_old_visible", 32'(v5), 32'd8);
        chk("re_done", 32'(done), 32'd1);
        chk("uns_idx", 32'(max_idx[0]), 32'd0);
        chk("uns_val", 32'(max_val[0]), 32'hFFFF);
        chk("tie_idx", 32'(max_idx[2]), 32'd0);
        repeat (2) @(posedge clk);
        chk("re_queue", 32'(q.size()), 32'd0);

        // Start pulse while busy must not trigger a second scan
        rnd = 1'b0; lat = 1; r0 = req_cnt;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        n = 0;
        while (!done && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        repeat (6) @(posedge clk);
        #1;
        chk("busy_pulse_done", 32'(done), 32'd1);
        chk("busy_pulse_reqs", 32'(req_cnt - r0), 32'd6);

        // Reset while waiting on row 3; its late answer must be dropped
        lat = 5;
        @(negedge clk); start = 1'b1;
        k = 0;
        do begin
            @(posedge clk);
            #1;
            k++;
        end while (!(m.rd_en && m.rd_addr == 3'd3) && k < 500);
        chk("reach_row3", 32'(m.rd_addr), 32'd3);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0; start = 1'b0; ignore_resp = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        chk_zero("mid_reset");
        repeat (8) @(posedge clk);
        @(negedge clk);
        chk_zero("late_valid");
        ignore_resp = 1'b0;
        for (int r = 0; r < 6; r++)
            for (int c = 0; c < 3; c++) mem[r][c] = 16'($urandom);
        scan(n);
        chk("post_reset_cycles", 32'(n), 32'd36);
        chk("post_reset_done", 32'(done), 32'd1);
        repeat (2) @(posedge clk);
        chk("post_reset_queue", 32'(q.size()), 32'd0);

        // Signed compare, single row
        @(negedge clk); s_start = 1'b1;
        @(posedge clk); #1;
        chk("sgn_rd_en", 32'(s.rd_en), 32'd1);
        @(posedge clk); #1;
        s.rd_valid = 1'b1;
        s.rd_data  = '{16'hFFFF, 16'h0001, 16'h8000};
        @(posedge clk); #1;
        s.rd_valid = 1'b0;
        chk("sgn_done", 32'(s_done), 32'd1);
        chk("sgn_idx", 32'(s_idx[0]), 32'd1);
        chk("sgn_val", 32'(s_val[0]), 32'd1);

        // One column, one row: done after L+1 cycles
        @(negedge clk); o_start = 1'b1;
        @(posedge clk); #1;
        chk("one_rd_en", 32'(o.rd_en), 32'd1);
        @(posedge clk); #1;
        o.rd_valid   = 1'b1;
        o.rd_data[0] = 16'd42;
        chk("one_early_done", 32'(o_done), 32'd0);
        @(posedge clk); #1;
        o.rd_valid = 1'b0;
        chk("one_done", 32'(o_done), 32'd1);
        chk("one_idx", 32'(o_idx[0]), 32'd0);
        chk("one_val", 32'(o_val[0]), 32'd42);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
